// File: rtl/key_pkg.sv
// Shared types and sizing helpers for the key/switch debounce block.
package key_pkg;

  typedef enum logic [1:0] {
    REL      = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_state_e;

  localparam int TICK_DIV_DEF   = 50_000;
  localparam int DB_TICKS_DEF   = 20;
  localparam int LONG_TICKS_DEF = 1000;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int TICK_W_DEF = cnt_w(TICK_DIV_DEF - 1);
  localparam int DB_W_DEF   = cnt_w(DB_TICKS_DEF);
  localparam int HOLD_W_DEF = cnt_w(LONG_TICKS_DEF);

endpackage

// File: rtl/key_sw_debounce_db_chan.sv
// One debounce channel: tick-counted acceptance of a new level, with optional
// press/release/long-press pulses for push-button use.
module db_chan
  import key_pkg::*;
#(
  parameter int DB_TICKS   = DB_TICKS_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter bit HAS_LONG   = 1'b1
) (
  input  logic fpga_clk_50,
  input  logic fpga_rst_n,
  input  logic tick,
  input  logic s,
  output logic level,
  output logic press_pls,
  output logic rel_pls,
  output logic long_pls
);

  localparam int DB_W   = cnt_w(DB_TICKS);
  localparam int HOLD_W = cnt_w(LONG_TICKS);
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_TICKS - 1);

  key_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;

  always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      state_q    <= REL;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      long_q     <= long_d;
    end
  end

  // A level change always beats a coincident tick: the mismatch test comes first.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      REL: begin
        if (s) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!s) begin
          state_d = REL;
        end else if (tick) begin
          if (db_cnt_q == DB_MAX) begin
            state_d    = HELD;
            level_d    = 1'b1;
            press_d    = HAS_LONG;
            hold_cnt_d = '0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
      end
      HELD: begin
        if (!s) begin
          state_d  = REL_DB;
          db_cnt_d = '0;
        end else if (tick && HAS_LONG && (hold_cnt_q != HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          long_d     = (hold_cnt_q == HOLD_PRE);
        end
      end
      REL_DB: begin
        // hold_cnt is left alone so a release bounce cannot re-arm long press.
        if (s) begin
          state_d = HELD;
        end else if (tick) begin
          if (db_cnt_q == DB_MAX) begin
            state_d = REL;
            level_d = 1'b0;
            rel_d   = HAS_LONG;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = REL;
    endcase
  end

  assign level     = level_q;
  assign press_pls = press_q;
  assign rel_pls   = rel_q;
  assign long_pls  = long_q;

endmodule

// File: rtl/key_sw_debounce.sv
// Input conditioning for the user push buttons and slide switches:
// 2-FF synchronisers, a shared debounce tick and one db_chan per pin.
module key_sw_debounce
  import key_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DB_TICKS   = DB_TICKS_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int N_KEY      = 3,
  parameter int N_SW       = 3
) (
  input  logic             fpga_clk_50,
  input  logic             fpga_rst_n,
  input  logic [N_KEY-1:0] usr_key_i,
  input  logic [N_SW-1:0]  usr_sw_i,
  output logic [N_KEY-1:0] key_level_o,
  output logic [N_KEY-1:0] key_press_o,
  output logic [N_KEY-1:0] key_release_o,
  output logic [N_KEY-1:0] key_long_o,
  output logic [N_SW-1:0]  sw_level_o
);

  localparam int TICK_W = cnt_w(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [N_KEY-1:0]  key_sync_p0, key_sync_p1;
  logic [N_SW-1:0]   sw_sync_p0, sw_sync_p1;
  logic [N_KEY-1:0]  key_s;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [N_SW-1:0]   sw_press_unused, sw_rel_unused, sw_long_unused;

  // Stage p0/p1: metastability guard; keys idle high (released) out of reset.
  always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      key_sync_p0 <= '1;
      key_sync_p1 <= '1;
      sw_sync_p0  <= '0;
      sw_sync_p1  <= '0;
    end else begin
      key_sync_p0 <= usr_key_i;
      key_sync_p1 <= key_sync_p0;
      sw_sync_p0  <= usr_sw_i;
      sw_sync_p1  <= sw_sync_p0;
    end
  end

  assign key_s = ~key_sync_p1;

  always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  for (genvar k = 0; k < N_KEY; k++) begin : g_key
    db_chan #(
      .DB_TICKS  (DB_TICKS),
      .LONG_TICKS(LONG_TICKS),
      .HAS_LONG  (1'b1)
    ) u_chan (
      .fpga_clk_50(fpga_clk_50),
      .fpga_rst_n (fpga_rst_n),
      .tick       (tick),
      .s          (key_s[k]),
      .level      (key_level_o[k]),
      .press_pls  (key_press_o[k]),
      .rel_pls    (key_release_o[k]),
      .long_pls   (key_long_o[k])
    );
  end

  for (genvar w = 0; w < N_SW; w++) begin : g_sw
    db_chan #(
      .DB_TICKS  (DB_TICKS),
      .LONG_TICKS(LONG_TICKS),
      .HAS_LONG  (1'b0)
    ) u_chan (
      .fpga_clk_50(fpga_clk_50),
      .fpga_rst_n (fpga_rst_n),
      .tick       (tick),
      .s          (sw_sync_p1[w]),
      .level      (sw_level_o[w]),
      .press_pls  (sw_press_unused[w]),
      .rel_pls    (sw_rel_unused[w]),
      .long_pls   (sw_long_unused[w])
    );
  end

endmodule
